irq_ctrl: RTL

//  Memory-mapped interrupt controller between the peripherals' int_req lines (uart, etc.)
//  and the picorv32 irq input. Latches NSRC sources as level or rising-edge events.

---
 rtl/irq_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller, NSRC level/edge sources -> one core irq line.
// Latency: bus ack 1 cycle after mem_valid; source change to int_req 3 cycles (5 with IRQ_CTRL_SYNC_EN).
// Backpressure: none; one registered ack per request, back-to-back requests acked every second cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mem_valid/mem_ready   bus request / one-cycle acknowledge
//   mem_addr[4:2]         register select; mem_wdata, mem_wstrb (0 = read); mem_rdata valid with mem_ready
//   irq_src[NSRC-1:0]     interrupt source lines
//   int_req               combined, registered interrupt request to the core
// Build option: define IRQ_CTRL_SYNC_EN to put a 2-flop synchronizer on irq_src for async pins.
//
// Register map (byte offset):
//   0x00 RAW RO, 0x04 PEND W1C, 0x08 ENABLE RW, 0x0C MODE RW (1=edge),
//   0x10 ID RO {any, .., lowest index[4:0]}, 0x14 SWSET WO, 0x18/0x1C read 0.
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_wdata,
    input  logic [3:0]      mem_wstrb,
    output logic [31:0]     mem_rdata,
    input  logic [NSRC-1:0] irq_src,
    output logic            int_req
);

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] s_d;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] mode;

    // A new request is accepted only when no ack is outstanding, so a held
    // mem_valid never produces two acks in a row.
    logic ack;
    logic wr_en;
    assign ack   = mem_valid && !mem_ready;
    assign wr_en = ack && (mem_wstrb != 4'b0000);

    logic [31:0] bmask;
    assign bmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

    logic [NSRC-1:0] wbits;
    logic [NSRC-1:0] wmask;
    assign wbits = mem_wdata[NSRC-1:0] & bmask[NSRC-1:0];
    assign wmask = bmask[NSRC-1:0];

    logic sel_pend, sel_enable, sel_mode, sel_swset;
    assign sel_pend   = wr_en && (mem_addr[4:2] == 3'd1);
    assign sel_enable = wr_en && (mem_addr[4:2] == 3'd2);
    assign sel_mode   = wr_en && (mem_addr[4:2] == 3'd3);
    assign sel_swset  = wr_en && (mem_addr[4:2] == 3'd5);

    // Edge mode uses s_d, which is tracked regardless of MODE, so switching a
    // source that is already high into edge mode does not raise an event.
    logic [NSRC-1:0] set_v;
    logic [NSRC-1:0] clr_v;
    assign set_v = ((mode & s & ~s_d) | (~mode & s)) | (sel_swset ? wbits : '0);
    assign clr_v = sel_pend ? wbits : '0;

    logic [NSRC-1:0] pe;
    assign pe = pend & enable;

    logic [4:0] low_idx;
    always_comb begin
        low_idx = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pe[i]) low_idx = 5'(i);
        end
    end

    logic [31:0] rd_val;
    always_comb begin
        rd_val = 32'd0;
        case (mem_addr[4:2])
            3'd0: rd_val = 32'(s);
            3'd1: rd_val = 32'(pend);
            3'd2: rd_val = 32'(enable);
            3'd3: rd_val = 32'(mode);
            3'd4: rd_val = (|pe) ? {1'b1, 26'd0, low_idx} : 32'd0;
            default: rd_val = 32'd0;
        endcase
    end

`ifdef IRQ_CTRL_SYNC_EN
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            s     <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            s     <= sync2;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) s <= '0;
        else        s <= irq_src;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_d       <= '0;
            pend      <= '0;
            enable    <= '0;
            mode      <= '0;
            int_req   <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            s_d       <= s;
            // Set wins: a new event in the clearing cycle keeps the bit pending.
            pend      <= (pend & ~clr_v) | set_v;
            if (sel_enable) enable <= (enable & ~wmask) | wbits;
            if (sel_mode)   mode   <= (mode & ~wmask) | wbits;
            int_req   <= |pe;
            mem_ready <= ack;
            mem_rdata <= ack ? rd_val : 32'd0;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{mem_addr, mem_wdata, bmask};

endmodule
